// File: rtl/boxcar_channel_scheduler.sv
// boxcar_channel_scheduler
//   Shares one boxcar (moving-average) datapath among NCH sample channels.
//   A round-robin arbiter takes one sample per turn. Each channel keeps its
//   own LEN-deep history, running sum and write pointer. The channel's window
//   average is returned, tagged with the channel index, on a valid/ready output.
//
// Ports
//   i_clk, i_reset   clock (rising edge), synchronous active-high reset
//   i_valid[NCH]     per-channel sample valid (held until accepted)
//   i_data[NCH*DW]   channel k sample at [k*DW +: DW]
//   o_ready[NCH]     one-hot accept strobe, only ever set in IDLE
//   o_valid, o_ch, o_data, i_ready   output average handshake
//   o_busy           high whenever the FSM is not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zero one history entry per cycle; zero all sums and pointers
// IDLE  | arbitrate; accept the granted channel's sample
// CALC  | update history/sum/pointer of the granted channel, register avg
// OUT   | hold the average until downstream takes it

module boxcar_channel_scheduler #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int LOG2_LEN = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NCH-1:0]           i_valid,
    input  logic [NCH*DW-1:0]        i_data,
    output logic [NCH-1:0]           o_ready,
    output logic                     o_valid,
    output logic [$clog2(NCH)-1:0]   o_ch,
    output logic [DW-1:0]            o_data,
    input  logic                     i_ready,
    output logic                     o_busy
);

    localparam int LEN  = 1 << LOG2_LEN;
    localparam int CHW  = $clog2(NCH);
    localparam int SW   = DW + LOG2_LEN;
    localparam int NENT = NCH * LEN;
    localparam int CLRW = $clog2(NENT);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_CALC,
        S_OUT
    } state_t;

    state_t              state;
    logic [CLRW-1:0]     clr_cnt;
    logic [CHW-1:0]      last_grant;
    logic [CHW-1:0]      cur_ch;
    logic [DW-1:0]       x_reg;

    logic [DW-1:0]       hist [NCH][LEN];
    logic [SW-1:0]       sum  [NCH];
    logic [LOG2_LEN-1:0] wptr [NCH];

    logic [CHW-1:0]      grant;
    logic                grant_found;
    logic [DW-1:0]       grant_sample;
    logic [DW-1:0]       old_sample;
    logic [SW-1:0]       new_sum;
    logic [CHW-1:0]      clr_ch;
    logic [LOG2_LEN-1:0] clr_pos;

    // last_grant + k reduced mod NCH; k never exceeds NCH so one fold suffices
    function automatic logic [CHW-1:0] wrap_idx(input int v);
        int r;
        r = (v >= NCH) ? (v - NCH) : v;
        return CHW'(r);
    endfunction

    // Round-robin search starting just after the previous grant
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            if (!grant_found && i_valid[wrap_idx(int'(last_grant) + k)]) begin
                grant       = wrap_idx(int'(last_grant) + k);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        o_ready = '0;
        if (state == S_IDLE && grant_found) begin
            o_ready[grant] = 1'b1;
        end
    end

    assign grant_sample = i_data[grant*DW +: DW];
    assign o_busy       = (state != S_IDLE);

    // The evicted sample is already part of the sum, so the result never underflows
    assign old_sample = hist[cur_ch][wptr[cur_ch]];
    assign new_sum    = sum[cur_ch] + SW'(x_reg) - SW'(old_sample);

    assign clr_ch  = clr_cnt[CLRW-1:LOG2_LEN];
    assign clr_pos = clr_cnt[LOG2_LEN-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            last_grant <= CHW'(NCH - 1);
            cur_ch     <= '0;
            x_reg      <= '0;
            o_valid    <= 1'b0;
            o_ch       <= '0;
            o_data     <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == CLRW'(NENT - 1)) begin
                        clr_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + CLRW'(1);
                    end
                end
                S_IDLE: begin
                    if (grant_found) begin
                        cur_ch <= grant;
                        x_reg  <= grant_sample;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    o_data  <= new_sum[SW-1:LOG2_LEN];
                    o_ch    <= cur_ch;
                    o_valid <= 1'b1;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        last_grant <= cur_ch;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // History storage carries no reset; CLEAR rebuilds it after every reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == S_CLEAR) begin
                hist[clr_ch][clr_pos] <= '0;
                for (int c = 0; c < NCH; c++) begin
                    sum[c]  <= '0;
                    wptr[c] <= '0;
                end
            end else if (state == S_CALC) begin
                hist[cur_ch][wptr[cur_ch]] <= x_reg;
                sum[cur_ch]                <= new_sum;
                wptr[cur_ch]               <= wptr[cur_ch] + LOG2_LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_boxcar_channel_scheduler.sv
module tb_boxcar_channel_scheduler;

    localparam int NCH      = 4;
    localparam int DW       = 8;
    localparam int LOG2_LEN = 3;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [NCH-1:0]    i_valid;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    o_ready;
    logic              o_valid;
    logic [1:0]        o_ch;
    logic [DW-1:0]     o_data;
    logic              i_ready;
    logic              o_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    boxcar_channel_scheduler #(
        .NCH      (NCH),
        .DW       (DW),
        .LOG2_LEN (LOG2_LEN)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_ch    (o_ch),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reset for two edges, release, then let the 32-cycle clear finish
    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_valid = '0;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (32) @(negedge clk);
        #1;
        check("clear_done_busy", o_busy, 0);
    endtask

    // One sample on one channel with i_ready=1; checks accept, latency and result
    task automatic do_sample(input string t, input int ch, input logic [7:0] d, input int exp);
        int waited;
        @(negedge clk);
        i_data[ch*DW +: DW] = d;
        i_valid[ch] = 1'b1;
        #1;
        waited = 0;
        while (!o_ready[ch] && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({t, "_accept_ready"}, o_ready, 32'(1) << ch);
        @(negedge clk);
        i_valid[ch] = 1'b0;
        #1;
        check({t, "_valid_calc"}, o_valid, 0);
        @(negedge clk);
        #1;
        check({t, "_valid_out"}, o_valid, 1);
        check({t, "_ch"}, o_ch, ch);
        check({t, "_data"}, o_data, exp);
    endtask

    int t3_exp [9] = '{31, 63, 95, 127, 159, 191, 223, 255, 255};
    int t4_in  [9] = '{8, 0, 0, 0, 0, 0, 0, 0, 0};
    int t4_exp [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    int t5_ch  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int t5_dat [8] = '{2, 4, 8, 16, 4, 8, 16, 32};

    initial begin
        int seen;
        int grants;
        int cyc;

        // T1: reset with every channel requesting
        i_reset = 1'b1;
        i_valid = '1;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 0);
        check("rst_o_ch", o_ch, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_busy", o_busy, 1);
        i_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("t1_ready_in_clear", o_ready, 0);
            check("t1_busy_in_clear", o_busy, 1);
            @(negedge clk);
            #1;
        end
        check("t1_first_grant", o_ready, 4'b0001);
        check("t1_idle_busy", o_busy, 0);
        i_valid = '0;

        // T2: single sample 8 on ch0
        do_sample("t2", 0, 8'd8, 1);

        // T3: nine full-scale samples on a fresh ch0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_sample("t3", 0, 8'd255, t3_exp[i]);
        end

        // T4: ch1 impulse leaves the window on the ninth sample
        for (int i = 0; i < 9; i++) begin
            do_sample("t4", 1, 8'(t4_in[i]), t4_exp[i]);
        end

        // T5: all channels requesting; round-robin with independent sums
        do_reset();
        @(negedge clk);
        i_data  = {8'd128, 8'd64, 8'd32, 8'd16};
        i_valid = '1;
        seen   = 0;
        grants = 0;
        cyc    = 0;
        while (seen < 8 && cyc < 100) begin
            #1;
            if (o_ready != '0) begin
                if (grants < 8) check("t5_grant", o_ready, 32'(1) << t5_ch[grants]);
                grants++;
            end
            if (o_valid) begin
                check("t5_ch", o_ch, t5_ch[seen]);
                check("t5_data", o_data, t5_dat[seen]);
                seen++;
                if (seen == 8) i_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        check("t5_outputs_seen", seen, 8);

        // T6: output stall, then reset while in OUT
        i_ready = 1'b0;
        i_data  = {8'd8, 8'd64, 8'd0, 8'd0};
        i_valid = 4'b1100;
        #1;
        check("t6_grant_ch2", o_ready, 4'b0100);
        @(negedge clk);
        i_valid[2] = 1'b0;
        #1;
        check("t6_valid_calc", o_valid, 0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t6_stall_valid", o_valid, 1);
            check("t6_stall_data", o_data, 24);
            check("t6_stall_ch", o_ch, 2);
            check("t6_stall_ready", o_ready, 0);
            @(negedge clk);
            #1;
        end
        i_reset = 1'b1;
        i_valid = '0;
        @(negedge clk);
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_data", o_data, 0);
        check("t6_rst_ch", o_ch, 0);
        check("t6_rst_busy", o_busy, 1);
        check("t6_rst_ready", o_ready, 0);
        i_reset = 1'b0;
        i_ready = 1'b1;
        repeat (32) @(negedge clk);
        #1;
        check("t6_clear_done_busy", o_busy, 0);
        do_sample("t6_post", 0, 8'd8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
